// File: rtl/param_reg_file.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// and a background clear sequencer with Busy/ClearDone handshake. Optional macro: REGFILE_BYPASS_EN.
module param_reg_file #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WriteEn,
    input  logic [ADDR_W-1:0] Waddr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [ADDR_W-1:0] RaddrA,
    input  logic [ADDR_W-1:0] RaddrB,
    output logic [DATA_W-1:0] DataOutA,
    output logic [DATA_W-1:0] DataOutB,
    input  logic              ClearReq,
    output logic              Busy,
    output logic              ClearDone,
    output logic              WriteAck
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              busy;
    logic              waddr_is_zero;

    // Busy comes straight off the state flop, so it is a registered output.
    assign busy          = (state_q == CLEAR);
    assign Busy          = busy;
    assign ClearDone     = done_q;
    assign waddr_is_zero = (ZERO_REG != 0) && (Waddr == '0);
    assign WriteAck      = WriteEn & ~busy & ~waddr_is_zero;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ClearReq) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the array is reset because software expects every register to read 0 after Reset;
    // that is a requirement of this block, not a default habit for memories.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (busy) begin
            regs[ptr_q] <= '0;
        end else if (WriteAck) begin
            regs[Waddr] <= DataIn;
        end
    end

    // Hardwired-zero check comes last so it wins over forwarding.
    always_comb begin
        DataOutA = regs[RaddrA];
`ifdef REGFILE_BYPASS_EN
        if (WriteAck && (RaddrA == Waddr)) DataOutA = DataIn;
`endif
        if ((ZERO_REG != 0) && (RaddrA == '0)) DataOutA = '0;
    end

    always_comb begin
        DataOutB = regs[RaddrB];
`ifdef REGFILE_BYPASS_EN
        if (WriteAck && (RaddrB == Waddr)) DataOutB = DataIn;
`endif
        if ((ZERO_REG != 0) && (RaddrB == '0)) DataOutB = '0;
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: one instance with ZERO_REG=0 and one with ZERO_REG=1
// share all inputs; a timeline-based reference model predicts every output each cycle.
module tb_param_reg_file;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int NO_CLR = -100000;

    logic       Clk = 1'b0;
    logic       Reset, WriteEn, ClearReq;
    logic [1:0] Waddr, RaddrA, RaddrB;
    logic [7:0] DataIn;

    logic [7:0] n_a, n_b, z_a, z_b;
    logic       n_busy, n_done, n_ack, z_busy, z_done, z_ack;

    always #5 Clk = ~Clk;

    param_reg_file #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(0)) dut (
        .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(n_a), .DataOutB(n_b),
        .ClearReq(ClearReq), .Busy(n_busy), .ClearDone(n_done), .WriteAck(n_ack)
    );

    param_reg_file #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(1)) dut_z (
        .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(z_a), .DataOutB(z_b),
        .ClearReq(ClearReq), .Busy(z_busy), .ClearDone(z_done), .WriteAck(z_ack)
    );

    typedef struct {
        int         cyc;
        logic [7:0] a, b, za, zb;
        logic       busy, done, ack, zack;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model as a timeline: the clear started at edge e0 zeroes register k at edge
    // e0+1+k, Busy holds for edges e0..e0+DEPTH-1 and ClearDone is seen at edge e0+DEPTH.
    logic [7:0] m_regs [DEPTH];
    int         edges = 0;
    int         e0    = NO_CLR;

    function automatic bit m_busy();
        return (edges >= e0) && (edges < e0 + DEPTH);
    endfunction

    function automatic bit m_ack(input bit zero);
        return WriteEn && !m_busy() && !(zero && Waddr == 2'd0);
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] addr, input bit zero);
        if (zero && addr == 2'd0) return 8'h00;
`ifdef REGFILE_BYPASS_EN
        if (m_ack(zero) && addr == Waddr) return DataIn;
`endif
        return m_regs[addr];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares mid-cycle, away from the edge.
    always @(negedge Clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e   = sb_q.pop_front();
            cyc = e.cyc;
            check("DataOutA",      32'(n_a),    32'(e.a));
            check("DataOutB",      32'(n_b),    32'(e.b));
            check("Busy",          32'(n_busy), 32'(e.busy));
            check("ClearDone",     32'(n_done), 32'(e.done));
            check("WriteAck",      32'(n_ack),  32'(e.ack));
            check("zero.DataOutA", 32'(z_a),    32'(e.za));
            check("zero.DataOutB", 32'(z_b),    32'(e.zb));
            check("zero.Busy",     32'(z_busy), 32'(e.busy));
            check("zero.ClearDone",32'(z_done), 32'(e.done));
            check("zero.WriteAck", 32'(z_ack),  32'(e.zack));
        end
    end

    // One clock cycle: drive inputs, push the expected outputs, then advance the model at the edge.
    task automatic cycle(input bit rst, input bit we, input logic [1:0] wa, input logic [7:0] din,
                         input logic [1:0] ra, input logic [1:0] rb, input bit cr, input bit chk);
        exp_t e;
        bit   b;
        Reset = rst; WriteEn = we; Waddr = wa; DataIn = din;
        RaddrA = ra; RaddrB = rb; ClearReq = cr;
        if (chk) begin
            e.cyc  = edges;
            e.a    = m_read(ra, 1'b0);
            e.b    = m_read(rb, 1'b0);
            e.za   = m_read(ra, 1'b1);
            e.zb   = m_read(rb, 1'b1);
            e.busy = m_busy();
            e.done = (edges == e0 + DEPTH);
            e.ack  = m_ack(1'b0);
            e.zack = m_ack(1'b1);
            sb_q.push_back(e);
        end
        b = m_busy();
        @(posedge Clk);
        edges++;
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            e0 = NO_CLR;
        end else begin
            // Only r0 can differ between the two instances and it always reads 0 on dut_z.
            if (we && !b) m_regs[wa] = din;
            if (b && (edges - e0 - 1) >= 0 && (edges - e0 - 1) < DEPTH) m_regs[edges - e0 - 1] = 8'h00;
            if (cr && !b) e0 = edges;
        end
        #1;
    endtask

    task automatic idle_read(input logic [1:0] ra, input logic [1:0] rb);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, ra, rb, 1'b0, 1'b1);
    endtask

    task automatic load_all();
        logic [7:0] vals [DEPTH];
        vals = '{8'd11, 8'd22, 8'd33, 8'd44};
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b0, 1'b1, 2'(i), vals[i], 2'(i), 2'((i + 1) % DEPTH), 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (m_regs[i]) m_regs[i] = 8'h00;

        // Reset, then every address reads 0.
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 2'd1, 8'h3C, 2'd0, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH; i++) idle_read(2'(i), 2'((i + 3) % DEPTH));

        // Write A5 to r2; read r2/r1 in the write cycle and the one after.
        cycle(1'b0, 1'b1, 2'd2, 8'hA5, 2'd2, 2'd1, 1'b0, 1'b1);
        idle_read(2'd2, 2'd1);

        // Write FF to r0: refused by the hardwired-zero instance.
        cycle(1'b0, 1'b1, 2'd0, 8'hFF, 2'd0, 2'd2, 1'b0, 1'b1);
        idle_read(2'd0, 2'd0);

        // Load 11/22/33/44, clear, with a refused write to r3 during Busy.
        load_all();
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 2'd0, 2'd3, 1'b1, 1'b1);
        for (int j = 0; j < 7; j++)
            cycle(1'b0, (j == 1), 2'd3, 8'h77, 2'(j % DEPTH), 2'((j + 2) % DEPTH), (j == 2), 1'b1);
        idle_read(2'd3, 2'd2);

        // ClearReq and a write to r1 on the same idle edge.
        load_all();
        cycle(1'b0, 1'b1, 2'd1, 8'h5A, 2'd1, 2'd2, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) idle_read(2'd1, 2'(j % DEPTH));

        // Reset in cycle 2 of a clear: no ClearDone, all registers 0.
        load_all();
        cycle(1'b0, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b1, 1'b1);
        idle_read(2'd2, 2'd3);
        cycle(1'b1, 1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 1'b1);
        for (int j = 0; j < 6; j++) idle_read(2'(j % DEPTH), 2'((j + 1) % DEPTH));

        // Randomised traffic.
        for (int n = 0; n < 500; n++)
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                  8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0), 1'b1);

        repeat (3) @(negedge Clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
